// File: rtl/sine_sched_pkg.sv
// Shared types and helpers for the multi-channel sine tone scheduler.
package sine_sched_pkg;

    localparam int unsigned PHASE_W_DEF = 16;
    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned MAX_CH      = 8;
    localparam int unsigned CH_IDX_W    = 3;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } sched_state_e;

    // First set bit of req searching upward from last+1, wrapping at n_ch.
    function automatic logic [CH_IDX_W-1:0] rr_pick(
        input logic [MAX_CH-1:0]   req,
        input logic [CH_IDX_W-1:0] last,
        input int unsigned         n_ch
    );
        logic [CH_IDX_W-1:0] pick;
        int                  idx;
        pick = last;
        // Walk from the farthest candidate to the nearest so the nearest wins.
        for (int k = MAX_CH; k > 0; k--) begin
            if (k <= int'(n_ch)) begin
                idx = (int'(last) + k) % int'(n_ch);
                if (req[idx[CH_IDX_W-1:0]]) begin
                    pick = idx[CH_IDX_W-1:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sine_tick_div.sv
// Per-channel sample-rate divider with pending and sticky overrun flags.
module sine_tick_div #(
    parameter int unsigned DIV_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_we,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             clr,
    output logic             pending,
    output logic             overrun
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             tick;

    assign tick = en && (div_q != '0) && (cnt_q >= div_q - DIV_W'(1));

    always_comb begin
        div_d     = div_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (cfg_we) begin
            div_d     = cfg_div;
            cnt_d     = '0;
            pending_d = 1'b0;
        end else begin
            if (div_q == '0) begin
                cnt_d = '0;
            end else if (en) begin
                cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
            end
            // A tick coinciding with the grant clearing pending re-arms it cleanly.
            if (tick) begin
                if (pending_q && !clr) begin
                    overrun_d = 1'b1;
                end
                pending_d = 1'b1;
            end else if (clr) begin
                pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q     <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/sine_tone_sched.sv
// Multi-channel tone scheduler sharing one sine lookup resource round-robin.
module sine_tone_sched
    import sine_sched_pkg::*;
#(
    parameter int unsigned NCH     = 4,
    parameter int unsigned PHASE_W = PHASE_W_DEF,
    parameter int unsigned DIV_W   = 32,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    cfg_we,
    input  logic [$clog2(NCH)-1:0]  cfg_ch,
    input  logic [DIV_W-1:0]        cfg_div,
    input  logic [PHASE_W-1:0]      cfg_step,
    output logic                    lut_req,
    output logic [PHASE_W-1:0]      lut_phase,
    input  logic                    lut_ready,
    input  logic                    lut_rvalid,
    input  logic [DATA_W-1:0]       lut_rdata,
    output logic [NCH*DATA_W-1:0]   sin_val,
    output logic [NCH-1:0]          sin_vld,
    output logic [NCH-1:0]          overrun
);

    localparam int unsigned CH_W = $clog2(NCH);

    sched_state_e        state_q, state_d;
    logic [CH_W-1:0]     grant_q, grant_d;
    logic [CH_W-1:0]     last_q, last_d;
    logic [PHASE_W-1:0]  lut_phase_q, lut_phase_d;
    logic                skip_q, skip_d;
    logic [NCH-1:0]      sin_vld_q, sin_vld_d;

    logic [PHASE_W-1:0]  phase_q [NCH];
    logic [PHASE_W-1:0]  phase_d [NCH];
    logic [PHASE_W-1:0]  step_q  [NCH];
    logic [PHASE_W-1:0]  step_d  [NCH];
    logic [DATA_W-1:0]   val_q   [NCH];
    logic [DATA_W-1:0]   val_d   [NCH];

    logic [NCH-1:0]      cfg_sel;
    logic [NCH-1:0]      pend;
    logic [NCH-1:0]      clr;
    logic [NCH-1:0]      pick_req;
    logic [MAX_CH-1:0]   req_ext;
    logic [CH_IDX_W-1:0] rr_g;
    logic [CH_W-1:0]     next_g;

    always_comb begin
        cfg_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            cfg_sel[i] = cfg_we && (cfg_ch == CH_W'(i));
        end
    end

    // A channel being reconfigured this cycle must not be granted with its stale phase.
    assign pick_req = pend & ~cfg_sel;

    always_comb begin
        req_ext            = '0;
        req_ext[NCH-1:0]   = pick_req;
    end

    assign rr_g   = rr_pick(req_ext, CH_IDX_W'(last_q), NCH);
    assign next_g = CH_W'(rr_g);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        sine_tick_div #(
            .DIV_W(DIV_W)
        ) u_div (
            .clk     (clk),
            .reset   (reset),
            .en      (en),
            .cfg_we  (cfg_sel[i]),
            .cfg_div (cfg_div),
            .clr     (clr[i]),
            .pending (pend[i]),
            .overrun (overrun[i])
        );

        assign sin_val[i*DATA_W +: DATA_W] = val_q[i];
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        lut_phase_d = lut_phase_q;
        skip_d      = skip_q;
        sin_vld_d   = '0;
        clr         = '0;
        phase_d     = phase_q;
        step_d      = step_q;
        val_d       = val_q;

        case (state_q)
            StIdle: begin
                if (|pick_req) begin
                    grant_d     = next_g;
                    lut_phase_d = phase_q[next_g];
                    skip_d      = 1'b0;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (cfg_sel[grant_q]) begin
                    skip_d = 1'b1;
                end
                if (lut_ready) begin
                    clr[grant_q] = 1'b1;
                    state_d      = StWait;
                end
            end
            StWait: begin
                if (cfg_sel[grant_q]) begin
                    skip_d = 1'b1;
                end
                if (lut_rvalid) begin
                    val_d[grant_q]     = lut_rdata;
                    sin_vld_d[grant_q] = 1'b1;
                    if (!skip_q) begin
                        phase_d[grant_q] = phase_q[grant_q] + step_q[grant_q];
                    end
                    last_d  = grant_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Configuration has the last word over any phase advance this cycle.
        for (int i = 0; i < NCH; i++) begin
            if (cfg_sel[i]) begin
                step_d[i]  = cfg_step;
                phase_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            last_q      <= CH_W'(NCH - 1);
            lut_phase_q <= '0;
            skip_q      <= 1'b0;
            sin_vld_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                phase_q[i] <= '0;
                step_q[i]  <= '0;
                val_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            lut_phase_q <= lut_phase_d;
            skip_q      <= skip_d;
            sin_vld_q   <= sin_vld_d;
            for (int i = 0; i < NCH; i++) begin
                phase_q[i] <= phase_d[i];
                step_q[i]  <= step_d[i];
                val_q[i]   <= val_d[i];
            end
        end
    end

    assign lut_req   = (state_q == StIssue);
    assign lut_phase = lut_phase_q;
    assign sin_vld   = sin_vld_q;

endmodule

// File: doc/sine_tone_sched.md
Name: sine_tone_sched

Overview:
Multi-channel tone scheduler that time-shares one sine lookup resource (quarter-wave LUT/CORDIC with a ready/valid interface) between NCH tone channels. Each channel owns:
- a programmable sample-rate divider,
- a phase accumulator.
On each channel sample tick the block issues that channel's phase to the shared resource, captures the returned sample and advances the phase. It sits between the host configuration path and the sine datapath, replacing one free-running generator per tone.

Parameters:
NCH, 4, number of tone channels (2..8)
PHASE_W, 16, phase accumulator width; full scale = 2*pi
DIV_W, 32, sample divider width
DATA_W, 16, signed sample width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-low (asserted when 0)
en  in  1  global run; 0 freezes dividers
cfg_we  in  1  configuration write strobe
cfg_ch  in  $clog2(NCH)  target channel
cfg_div  in  DIV_W  clocks per sample; 0 = channel off
cfg_step  in  PHASE_W  phase increment per sample
lut_req  out  1  request to sine resource
lut_phase  out  PHASE_W  phase for request
lut_ready  in  1  resource accepts request
lut_rvalid  in  1  result valid, one cycle
lut_rdata  in  DATA_W  signed sine result
sin_val  out  NCH*DATA_W  per-channel latest sample, channel i at [i*DATA_W +: DATA_W]
sin_vld  out  NCH  one-cycle strobe on sin_val[i] update
overrun  out  NCH  sticky: tick arrived while previous still pending

Behaviour:
- Reset: all outputs 0, and all internal state 0: cnt, phase, div, step, pending, last_grant=NCH-1, FSM=IDLE.
- Divider, per channel, when en=1 and div!=0:
  - cnt>=div-1: cnt<=0 and set pending[i].
  - otherwise cnt<=cnt+1.
- Divider when div=0: cnt held 0, no ticks.
- Divider when en=0: cnt holds. pending is kept and in-flight work completes.
- Tick with pending[i] already 1: overrun[i]<=1 (sticky until reset), tick dropped.
- Tick in the same cycle as pending[i] is cleared: pending stays 1, no overrun.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if any pending, grant g = first pending channel round-robin from last_grant+1. Latch lut_phase=phase[g] and go to ISSUE.
  - ISSUE: lut_req=1, held stable until lut_ready=1. On handshake, clear pending[g] and go to WAIT.
  - WAIT: on lut_rvalid:
    - sin_val[g]<=lut_rdata;
    - sin_vld[g]=1 for one cycle;
    - phase[g]<=phase[g]+step[g], modulo 2^PHASE_W;
    - last_grant<=g;
    - return to IDLE.
  - lut_rvalid outside WAIT is ignored.
- Latency: pending set at edge T, lut_req high from T+1. Minimum 3 cycles per sample: IDLE, ISSUE with ready, WAIT with rvalid.
- Only one request is outstanding at a time.
- Configuration write (cfg_we) to channel c:
  - div[c]<=cfg_div, step[c]<=cfg_step.
  - cnt[c]<=0, phase[c]<=0, pending[c]<=0.
  - overrun[c] is unchanged.
- Configuration write to the channel granted in ISSUE: the request is completed unchanged.
- Configuration write to the granted channel in ISSUE or WAIT:
  - the result is still delivered to sin_val[c] and sin_vld[c];
  - the phase advance is suppressed, so phase stays 0.
- Configuration write wins over a tick in the same cycle.
- Async reset mid-transaction: lut_req drops immediately and the FSM returns to IDLE. The resource must be reset by the same signal.

Decomposition:
- Package sine_sched_pkg holds:
  - the FSM state enum;
  - PHASE_W/DATA_W defaults;
  - the round-robin pick function, first set bit rotated from last_grant+1.
- One sub-module, sine_tick_div, holds the per-channel divider plus the pending/overrun logic. It is instantiated NCH times.

Test Plan:
- Single channel: ch0 div=10, step=1024, resource ready=1, rvalid 1 cycle after accept.
  - Requests every 10 clocks, lut_phase 0, 1024, 2048, ...
  - sin_vld[0] every 10 clocks.
  - Phase wraps to 0 after 64 samples.
- Two channels, same cycle: ch0 and ch1 div=8 configured together.
  - Grants alternate 0,1,0,1 via round-robin.
  - Both sin_vld observed each 8-clock period.
  - No overrun.
- Stall and overrun: ch2 div=4, lut_ready held 0 for 10 cycles.
  - lut_req and lut_phase stable throughout the stall.
  - overrun[2]=1 and stays set after ready returns.
- Config during WAIT: write ch0 while it is in flight.
  - sin_vld[0] still pulses.
  - Next request for ch0 carries phase 0.
- en=0 for 20 cycles mid-run: no new lut_req after in-flight completion. cnt resumes from the held value.
- Reset low asserted during ISSUE: lut_req=0 and all outputs 0 within the same cycle. Normal operation resumes after release.
